pwm_update_sched: RTL and testbench

Per-channel counter generator and shadow-register update scheduler for the 4-channel PWM output stage. It produces the packed `counter`, `period_reg` and `DC_reg` buses consumed by the PWM comparator logic. Bus-side writes land in shadow registers and are committed only at each channel's period wrap, so a period or duty-cycle change never produces a truncated or glitched PWM cycle. It sits between the Wishbone register file and the PWM output stage, in the `chosen_clk` domain.

---
 rtl/pwm_pkg.sv | 14 +
 rtl/pwm_ch_seq.sv | 86 ++++++++
 rtl/pwm_update_sched.sv | 50 +++++
 tb/tb_pwm_update_sched.sv | 186 ++++++++++++++++++
 4 files changed

// File: rtl/pwm_pkg.sv
// rtl/pwm_pkg.sv - shared constants and types for the PWM update scheduler
package pwm_pkg;
    localparam int PWM_CW     = 16;
    localparam int PWM_NUM_CH = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } pwm_ch_state_t;

    localparam logic PWM_SEL_PERIOD = 1'b0;
    localparam logic PWM_SEL_DC     = 1'b1;
endpackage

// File: rtl/pwm_ch_seq.sv
// rtl/pwm_ch_seq.sv - one PWM channel: FSM, counter, shadow slots and commit
module pwm_ch_seq
    import pwm_pkg::*;
#(
    parameter int CW = PWM_CW
) (
    input  logic          chosen_clk,
    input  logic          rst,
    input  logic          cnt_en,
    input  logic          oneshot,
    input  logic          wr_period,
    input  logic          wr_dc,
    input  logic [CW-1:0] wr_data,
    output logic [CW-1:0] counter,
    output logic [CW-1:0] period_reg,
    output logic [CW-1:0] dc_reg,
    output logic          pend_period,
    output logic          pend_dc,
    output logic          period_done
);
    pwm_ch_state_t state_q, state_d;
    logic [CW-1:0] counter_d;
    logic [CW-1:0] shadow_period, shadow_dc;
    logic          wrap, commit;

    // A zero period would underflow period-1, so it is treated as wrapping every cycle.
    assign wrap        = (period_reg == '0) || (counter >= period_reg - CW'(1));
    assign period_done = (state_q == RUN) && wrap;
    assign commit      = (state_q == RUN) ? wrap : 1'b1;

    always_comb begin
        state_d   = state_q;
        counter_d = '0;
        case (state_q)
            IDLE: begin
                if (cnt_en) state_d = RUN;
            end
            RUN: begin
                if (!cnt_en)
                    state_d = IDLE;
                else if (wrap && oneshot)
                    state_d = HALT;
                if (cnt_en && !wrap)
                    counter_d = counter + CW'(1);
            end
            HALT: begin
                if (!cnt_en) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge chosen_clk or posedge rst) begin
        if (rst) begin
            state_q       <= IDLE;
            counter       <= '0;
            period_reg    <= '0;
            dc_reg        <= '0;
            shadow_period <= '0;
            shadow_dc     <= '0;
            pend_period   <= 1'b0;
            pend_dc       <= 1'b0;
        end else begin
            state_q <= state_d;
            counter <= counter_d;
            // Commit uses the pending bits from before this edge, so a write
            // accepted on a wrap edge waits for the next wrap.
            if (commit && pend_period) begin
                period_reg  <= shadow_period;
                pend_period <= 1'b0;
            end
            if (commit && pend_dc) begin
                dc_reg  <= shadow_dc;
                pend_dc <= 1'b0;
            end
            if (wr_period) begin
                shadow_period <= wr_data;
                pend_period   <= 1'b1;
            end
            if (wr_dc) begin
                shadow_dc <= wr_data;
                pend_dc   <= 1'b1;
            end
        end
    end
endmodule

// File: rtl/pwm_update_sched.sv
// rtl/pwm_update_sched.sv - 4-channel PWM counter generator and shadow update scheduler
module pwm_update_sched
    import pwm_pkg::*;
#(
    parameter int NUM_CH = PWM_NUM_CH,
    parameter int CW     = PWM_CW
) (
    input  logic                 chosen_clk,
    input  logic                 rst,
    input  logic                 cnt_en,
    input  logic                 oneshot,
    input  logic                 wr_valid,
    output logic                 wr_ready,
    input  logic [1:0]           wr_ch,
    input  logic                 wr_sel,
    input  logic [CW-1:0]        wr_data,
    output logic [NUM_CH*CW-1:0] counter,
    output logic [NUM_CH*CW-1:0] period_reg,
    output logic [NUM_CH*CW-1:0] DC_reg,
    output logic [NUM_CH-1:0]    upd_pending,
    output logic [NUM_CH-1:0]    period_done
);
    logic [NUM_CH-1:0] pend_period, pend_dc;
    logic              wr_fire;

    assign wr_ready    = ~((wr_sel == PWM_SEL_DC) ? pend_dc[wr_ch] : pend_period[wr_ch]);
    assign wr_fire     = wr_valid & wr_ready;
    assign upd_pending = pend_period | pend_dc;

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        logic hit;
        assign hit = wr_fire && (wr_ch == 2'(i));

        pwm_ch_seq #(.CW(CW)) u_ch (
            .chosen_clk  (chosen_clk),
            .rst         (rst),
            .cnt_en      (cnt_en),
            .oneshot     (oneshot),
            .wr_period   (hit && (wr_sel == PWM_SEL_PERIOD)),
            .wr_dc       (hit && (wr_sel == PWM_SEL_DC)),
            .wr_data     (wr_data),
            .counter     (counter[i*CW +: CW]),
            .period_reg  (period_reg[i*CW +: CW]),
            .dc_reg      (DC_reg[i*CW +: CW]),
            .pend_period (pend_period[i]),
            .pend_dc     (pend_dc[i]),
            .period_done (period_done[i])
        );
    end
endmodule

// File: tb/tb_pwm_update_sched.sv
// tb/tb_pwm_update_sched.sv - randomized self-checking bench with a behavioural channel model
module tb_pwm_update_sched;
    logic        chosen_clk = 1'b0;
    logic        rst;
    logic        cnt_en, oneshot, wr_valid, wr_sel;
    logic [1:0]  wr_ch;
    logic [15:0] wr_data;
    logic        wr_ready;
    logic [63:0] counter, period_reg, DC_reg;
    logic [3:0]  upd_pending, period_done;

    pwm_update_sched dut (
        .chosen_clk  (chosen_clk),
        .rst         (rst),
        .cnt_en      (cnt_en),
        .oneshot     (oneshot),
        .wr_valid    (wr_valid),
        .wr_ready    (wr_ready),
        .wr_ch       (wr_ch),
        .wr_sel      (wr_sel),
        .wr_data     (wr_data),
        .counter     (counter),
        .period_reg  (period_reg),
        .DC_reg      (DC_reg),
        .upd_pending (upd_pending),
        .period_done (period_done)
    );

    always #5 chosen_clk = ~chosen_clk;

    int n_chk = 0;
    int n_err = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: 0 = stopped, 1 = counting, 2 = halted after a one-shot period.
    int m_mode [4];
    int m_cnt  [4];
    int m_per  [4];
    int m_dc   [4];
    int m_new_per [4];
    int m_new_dc  [4];
    bit m_has_per [4];
    bit m_has_dc  [4];

    task automatic model_reset();
        for (int n = 0; n < 4; n++) begin
            m_mode[n] = 0; m_cnt[n] = 0; m_per[n] = 0; m_dc[n] = 0;
            m_new_per[n] = 0; m_new_dc[n] = 0; m_has_per[n] = 0; m_has_dc[n] = 0;
        end
    endtask

    function automatic bit m_last(int n);
        return (m_per[n] == 0) || (m_cnt[n] + 1 >= m_per[n]);
    endfunction

    function automatic bit m_ready();
        return wr_sel ? !m_has_dc[wr_ch] : !m_has_per[wr_ch];
    endfunction

    task automatic model_step();
        bit take = wr_valid && m_ready();
        for (int n = 0; n < 4; n++) begin
            bit last = m_last(n);
            bit counting = (m_mode[n] == 1);
            if (!counting || last) begin
                if (m_has_per[n]) begin m_per[n] = m_new_per[n]; m_has_per[n] = 0; end
                if (m_has_dc[n])  begin m_dc[n]  = m_new_dc[n];  m_has_dc[n]  = 0; end
            end
            m_cnt[n] = (counting && cnt_en && !last) ? m_cnt[n] + 1 : 0;
            case (m_mode[n])
                0: if (cnt_en) m_mode[n] = 1;
                1: if (!cnt_en) m_mode[n] = 0; else if (last && oneshot) m_mode[n] = 2;
                default: if (!cnt_en) m_mode[n] = 0;
            endcase
        end
        if (take) begin
            if (wr_sel) begin m_new_dc[wr_ch] = wr_data;  m_has_dc[wr_ch] = 1; end
            else        begin m_new_per[wr_ch] = wr_data; m_has_per[wr_ch] = 1; end
        end
    endtask

    task automatic check_outputs();
        logic [63:0] e_cnt, e_per, e_dc;
        logic [3:0]  e_pend, e_done;
        for (int n = 0; n < 4; n++) begin
            e_cnt[n*16 +: 16] = 16'(m_cnt[n]);
            e_per[n*16 +: 16] = 16'(m_per[n]);
            e_dc[n*16 +: 16]  = 16'(m_dc[n]);
            e_pend[n] = m_has_per[n] | m_has_dc[n];
            e_done[n] = (m_mode[n] == 1) && m_last(n);
        end
        check_eq("counter", counter, e_cnt);
        check_eq("period_reg", period_reg, e_per);
        check_eq("DC_reg", DC_reg, e_dc);
        check_eq("upd_pending", 64'(upd_pending), 64'(e_pend));
        check_eq("period_done", 64'(period_done), 64'(e_done));
    endtask

    // Inputs are already driven; check ready, advance model and DUT by one edge, check state.
    task automatic cycle();
        #1;
        check_eq("wr_ready", 64'(wr_ready), 64'(m_ready()));
        model_step();
        @(negedge chosen_clk);
        check_outputs();
    endtask

    task automatic rand_inputs();
        if ($urandom_range(cnt_en ? 39 : 4) == 0) cnt_en = ~cnt_en;
        if ($urandom_range(59) == 0) oneshot = ~oneshot;
        wr_valid = ($urandom_range(2) == 0);
        wr_ch    = 2'($urandom_range(3));
        wr_sel   = 1'($urandom_range(1));
        wr_data  = 16'($urandom_range(12));
    endtask

    int seq_exp [6] = '{0, 1, 2, 3, 4, 0};

    initial begin
        rst = 1'b1; cnt_en = 1'b0; oneshot = 1'b0;
        wr_valid = 1'b0; wr_ch = 2'd0; wr_sel = 1'b0; wr_data = 16'd0;
        model_reset();
        @(negedge chosen_clk);
        @(negedge chosen_clk);
        check_eq("reset_counter", counter, 64'd0);
        check_eq("reset_wr_ready", 64'(wr_ready), 64'd1);
        check_outputs();
        rst = 1'b0;

        wr_valid = 1'b1; wr_ch = 2'd0; wr_sel = 1'b0; wr_data = 16'd5;
        cycle();
        wr_sel = 1'b1; wr_data = 16'd2;
        cycle();
        wr_valid = 1'b0;
        cycle();
        check_eq("ch0_period_idle", 64'(period_reg[15:0]), 64'd5);
        check_eq("ch0_dc_idle", 64'(DC_reg[15:0]), 64'd2);
        cnt_en = 1'b1;
        cycle();
        for (int k = 0; k < 6; k++) begin
            check_eq("ch0_count_seq", 64'(counter[15:0]), 64'(seq_exp[k]));
            check_eq("ch0_done_seq", 64'(period_done[0]), 64'(seq_exp[k] == 4));
            cycle();
        end

        for (int i = 0; i < 3000; i++) begin
            rand_inputs();
            cycle();
        end

        // Load long periods on every channel so the reset hits running channels with pending updates.
        cnt_en = 1'b1; oneshot = 1'b0;
        for (int i = 0; i < 40; i++) begin
            wr_valid = 1'b1; wr_ch = 2'(i % 4); wr_sel = 1'(i / 4 % 2); wr_data = 16'(20 + i);
            cycle();
        end
        wr_valid = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        check_eq("rst_counter", counter, 64'd0);
        check_eq("rst_period", period_reg, 64'd0);
        check_eq("rst_dc", DC_reg, 64'd0);
        check_eq("rst_pending", 64'(upd_pending), 64'd0);
        check_eq("rst_done", 64'(period_done), 64'd0);
        check_eq("rst_wr_ready", 64'(wr_ready), 64'd1);
        model_reset();
        @(negedge chosen_clk);
        check_outputs();
        rst = 1'b0;
        for (int i = 0; i < 500; i++) begin
            rand_inputs();
            cycle();
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
